// File: rtl/spi_xfer_ctrl_if.sv
// Bundle between the SPI transaction controller, its two requesters and the
// shared SPI byte engine.
//
// Handshakes: req is a level; the controller answers with a one-hot gnt held
// for the whole burst. byte_rd pulses once per byte when tx_dataN has been
// captured, and the requester must show the next byte by the following cycle.
// spi_wr is a load strobe that is issued only after spi_idle was seen high.
// spi_done_tick is a completion pulse, and the controller accepts it only
// while a byte is in flight. rx_valid and xfer_done are 1-cycle pulses with no
// back-pressure.
interface spi_xfer_ctrl_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [7:0]       dvsr0;
  logic [7:0]       dvsr1;
  logic [7:0]       tx_data0;
  logic [7:0]       tx_data1;
  logic [1:0]       gnt;
  logic             byte_rd;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             xfer_done;
  logic [1:0]       ss_n;
  logic [7:0]       spi_din;
  logic [7:0]       spi_dvsr;
  logic             spi_wr;
  logic [7:0]       spi_dout;
  logic             spi_done_tick;
  logic             spi_idle;

  // Controller side
  modport slave (
    input  req, len0, len1, dvsr0, dvsr1, tx_data0, tx_data1,
    input  spi_dout, spi_done_tick, spi_idle,
    output gnt, byte_rd, rx_data, rx_valid, xfer_done, ss_n,
    output spi_din, spi_dvsr, spi_wr
  );

  // Requesters and engine side
  modport master (
    output req, len0, len1, dvsr0, dvsr1, tx_data0, tx_data1,
    output spi_dout, spi_done_tick, spi_idle,
    input  gnt, byte_rd, rx_data, rx_valid, xfer_done, ss_n,
    input  spi_din, spi_dvsr, spi_wr
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Two-port round-robin transaction controller in front of a shared SPI byte
// engine. It grants one requester, drives its slave select around a burst of
// len+1 bytes, and returns every received byte to that requester.
module spi_xfer_ctrl #(
  parameter int LEN_W  = 4,
  parameter int CS_GAP = 2
) (
  input  logic            clk,
  input  logic            reset,
  spi_xfer_ctrl_if.slave  bus,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // The gap counter counts CS_GAP-1 down to 0, so CS_GAP cycles in total.
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ss_n_q, ss_n_d;
  logic             spi_wr_q, spi_wr_d;
  logic             byte_rd_q, byte_rd_d;
  logic             rx_valid_q, rx_valid_d;
  logic             xfer_done_q, xfer_done_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [7:0]       spi_din_q, spi_din_d;
  logic [7:0]       spi_dvsr_q, spi_dvsr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ptr_q, ptr_d;   // requester favoured when both ask

  logic             any_req;
  logic             win;
  logic [7:0]       win_dvsr;

  assign any_req = |bus.req;

  // Round-robin choice: a lone requester wins outright, a tie goes to ptr_q.
  always_comb begin
    win = ptr_q;
    if (bus.req == 2'b01) begin
      win = 1'b0;
    end else if (bus.req == 2'b10) begin
      win = 1'b1;
    end
    win_dvsr = win ? bus.dvsr1 : bus.dvsr0;
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      ss_n_q      <= 2'b11;
      spi_wr_q    <= 1'b0;
      byte_rd_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      xfer_done_q <= 1'b0;
      rx_data_q   <= 8'h00;
      spi_din_q   <= 8'h00;
      spi_dvsr_q  <= 8'h01;
      cnt_q       <= '0;
      gap_q       <= '0;
      ptr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ss_n_q      <= ss_n_d;
      spi_wr_q    <= spi_wr_d;
      byte_rd_q   <= byte_rd_d;
      rx_valid_q  <= rx_valid_d;
      xfer_done_q <= xfer_done_d;
      rx_data_q   <= rx_data_d;
      spi_din_q   <= spi_din_d;
      spi_dvsr_q  <= spi_dvsr_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      ptr_q       <= ptr_d;
    end
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_SETUP;
      ST_SETUP: if (gap_q == '0) state_d = ST_LOAD;
      ST_LOAD:  if (bus.spi_idle) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.spi_done_tick) begin
          state_d = (cnt_q == '0) ? ST_HOLD : ST_LOAD;
        end
      end
      ST_HOLD:  if (gap_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath updates; strobes default low so they last one cycle.
  always_comb begin
    gnt_d       = gnt_q;
    ss_n_d      = ss_n_q;
    spi_wr_d    = 1'b0;
    byte_rd_d   = 1'b0;
    rx_valid_d  = 1'b0;
    xfer_done_d = 1'b0;
    rx_data_d   = rx_data_q;
    spi_din_d   = spi_din_q;
    spi_dvsr_d  = spi_dvsr_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    ptr_d       = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d      = win ? 2'b10 : 2'b01;
          ss_n_d     = win ? 2'b01 : 2'b10;
          cnt_d      = win ? bus.len1 : bus.len0;
          // A divider of zero would stall the engine, so it runs at 1 instead.
          spi_dvsr_d = (win_dvsr == 8'h00) ? 8'h01 : win_dvsr;
          gap_d      = GAP_LOAD;
        end
      end
      ST_SETUP: begin
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
      end
      ST_LOAD: begin
        if (bus.spi_idle) begin
          spi_din_d = gnt_q[1] ? bus.tx_data1 : bus.tx_data0;
          spi_wr_d  = 1'b1;
          byte_rd_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.spi_done_tick) begin
          rx_data_d  = bus.spi_dout;
          rx_valid_d = 1'b1;
          if (cnt_q == '0) begin
            gap_d = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (gap_q == '0) begin
          gnt_d       = 2'b00;
          ss_n_d      = 2'b11;
          xfer_done_d = 1'b1;
          // Having served requester 0 means requester 1 is favoured next.
          ptr_d       = gnt_q[0];
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.ss_n      = ss_n_q;
  assign bus.spi_wr    = spi_wr_q;
  assign bus.byte_rd   = byte_rd_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.xfer_done = xfer_done_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.spi_din   = spi_din_q;
  assign bus.spi_dvsr  = spi_dvsr_q;
  assign dbg_state     = state_q;

endmodule
